// File: rtl/thumb_read_arbiter.sv
// ============================================================================
// Module      : thumb_read_arbiter
// Description : Round-robin arbiter that shares the single read port of the
//               40x30 thumbnail buffer between two requesters. One read is
//               issued per cycle. Each response is tagged and returned to the
//               requester that won, at a fixed latency. Coordinates outside
//               the buffer are answered locally with OOR_VALUE, and the
//               buffer is not addressed for them.
//               Optional feature macro: THUMB_ARB_STATS_EN adds per-requester
//               saturating grant counters and a synchronous stats_clear input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module thumb_read_arbiter #(
  parameter int          READ_LATENCY = 1,
  parameter int          X_MAX        = 39,
  parameter int          Y_MAX        = 29,
  parameter logic [7:0]  OOR_VALUE    = 8'h00
) (
  input  logic        read_clock,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  input  logic [5:0]  req_x0,
  input  logic [5:0]  req_x1,
  input  logic [4:0]  req_y0,
  input  logic [4:0]  req_y1,
  output logic [1:0]  req_ready,
  output logic [1:0]  resp_valid,
  output logic [7:0]  resp_data,
  output logic        resp_oor,
  output logic [5:0]  read_x,
  output logic [4:0]  read_y,
  input  logic [7:0]  read_q
`ifdef THUMB_ARB_STATS_EN
  ,
  input  logic        stats_clear,
  output logic [15:0] grant_count0,
  output logic [15:0] grant_count1
`endif
);

  // The coordinate limits are narrowed to the port widths so that the
  // range compares do not mix widths.
  localparam logic [5:0] X_LIM = 6'(X_MAX);
  localparam logic [4:0] Y_LIM = 5'(Y_MAX);

  // last_grant holds the requester that won the most recent handshake.
  logic                  last_grant;
  logic                  handshake;
  logic                  sel;
  logic [5:0]            sel_x;
  logic [4:0]            sel_y;
  logic                  sel_oor;

  // The in-flight tracking pipeline has one stage per clock between accept
  // and the response register.
  logic [READ_LATENCY:0] pipe_valid;
  logic [READ_LATENCY:0] pipe_tag;
  logic [READ_LATENCY:0] pipe_oor;

  // Round-robin grant. A single requester always wins. When both request,
  // the one that did not win last time is granted.
  always_comb begin
    req_ready = 2'b00;
    case (req_valid)
      2'b01:   req_ready = 2'b01;
      2'b10:   req_ready = 2'b10;
      2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
      default: req_ready = 2'b00;
    endcase
  end

  // Select the coordinates of the granted requester and classify the range.
  always_comb begin
    handshake = |(req_valid & req_ready);
    sel       = req_ready[1];
    sel_x     = sel ? req_x1 : req_x0;
    sel_y     = sel ? req_y1 : req_y0;
    sel_oor   = (sel_x > X_LIM) | (sel_y > Y_LIM);
  end

  // Track the winner. The reset value of 1 lets requester 0 win the first
  // contention.
  always_ff @(posedge read_clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (handshake) begin
      last_grant <= sel;
    end
  end

  // Update the buffer address only for in-range handshakes. Out-of-range and
  // idle cycles leave the previous address in place.
  always_ff @(posedge read_clock or negedge reset_n) begin
    if (!reset_n) begin
      read_x <= 6'd0;
      read_y <= 5'd0;
    end else if (handshake && !sel_oor) begin
      read_x <= sel_x;
      read_y <= sel_y;
    end
  end

  // Shift the valid, tag and out-of-range flags along with the buffer read.
  always_ff @(posedge read_clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid <= '0;
      pipe_tag   <= '0;
      pipe_oor   <= '0;
    end else begin
      pipe_valid[0] <= handshake;
      pipe_tag[0]   <= sel;
      pipe_oor[0]   <= sel_oor;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
        pipe_oor[i]   <= pipe_oor[i-1];
      end
    end
  end

  // Register the response. Data is returned to zero between pulses so that a
  // stale pixel never lingers on the bus.
  always_ff @(posedge read_clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 2'b00;
      resp_data  <= 8'h00;
      resp_oor   <= 1'b0;
    end else if (pipe_valid[READ_LATENCY]) begin
      resp_valid <= pipe_tag[READ_LATENCY] ? 2'b10 : 2'b01;
      resp_data  <= pipe_oor[READ_LATENCY] ? OOR_VALUE : read_q;
      resp_oor   <= pipe_oor[READ_LATENCY];
    end else begin
      resp_valid <= 2'b00;
      resp_data  <= 8'h00;
      resp_oor   <= 1'b0;
    end
  end

`ifdef THUMB_ARB_STATS_EN
  // Per-requester saturating handshake counters. A clear takes priority over
  // an increment in the same cycle.
  always_ff @(posedge read_clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_count0 <= 16'h0000;
      grant_count1 <= 16'h0000;
    end else if (stats_clear) begin
      grant_count0 <= 16'h0000;
      grant_count1 <= 16'h0000;
    end else if (handshake) begin
      if (!sel && grant_count0 != 16'hFFFF) grant_count0 <= grant_count0 + 16'd1;
      if ( sel && grant_count1 != 16'hFFFF) grant_count1 <= grant_count1 + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
